// File: rtl/flow_ctrl_fsm_n.sv
// Flow-control state machine for an NCH-channel FIFO bank.
// Watches per-channel FIFO flags and drives pause/continue/error back to
// the sources, a global idle flag, and the almost-full/almost-empty
// thresholds the FIFOs should use. All outputs are registered.
module flow_ctrl_fsm_n #(
  parameter int               NCH    = 4,
  parameter int               THR_W  = 3,
  parameter logic [THR_W-1:0] AF_RST = 3'd6,
  parameter logic [THR_W-1:0] AE_RST = 3'd1,
  parameter int               CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             iniciar_in,
  input  logic             err_clr_in,
  input  logic [THR_W-1:0] umbral_af_in,
  input  logic [THR_W-1:0] umbral_ae_in,
  input  logic [NCH-1:0]   almost_full_in,
  input  logic [NCH-1:0]   full_in,
  input  logic [NCH-1:0]   almost_empty_in,
  input  logic [NCH-1:0]   empty_in,
  output logic [THR_W-1:0] umbral_af_out,
  output logic [THR_W-1:0] umbral_ae_out,
  output logic [4:0]       estado,
  output logic             idle,
  output logic [NCH-1:0]   pausa,
  output logic [NCH-1:0]   continuar,
  output logic [NCH-1:0]   error,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } stateT;

  stateT            stateQ;
  stateT            stateNext;
  logic [THR_W-1:0] afNext;
  logic [THR_W-1:0] aeNext;
  logic             idleNext;
  logic [NCH-1:0]   pausaNext;
  logic [NCH-1:0]   contNext;
  logic [NCH-1:0]   errorNext;
  logic [CNT_W-1:0] cntNext;
  logic             anyFull;
  logic             allEmpty;
  logic             enterError;
  logic [NCH-1:0]   pauseSet;
  logic [NCH-1:0]   pauseClr;
  logic [NCH-1:0]   hystPausa;

  assign estado = stateQ;

  // Next state and next registered outputs; every target gets a default first.
  always_comb begin
    stateNext  = stateQ;
    afNext     = umbral_af_out;
    aeNext     = umbral_ae_out;
    idleNext   = 1'b0;
    pausaNext  = '0;
    contNext   = '0;
    errorNext  = '0;
    cntNext    = err_cnt;
    enterError = 1'b0;

    anyFull   = |full_in;
    allEmpty  = &empty_in;
    pauseSet  = almost_full_in;
    pauseClr  = (almost_empty_in | empty_in) & ~almost_full_in;
    hystPausa = (pausa & ~pauseClr) | pauseSet;

    case (stateQ)
      ST_RESET: begin
        stateNext = ST_INIT;
      end
      ST_INIT: begin
        afNext = umbral_af_in;
        aeNext = umbral_ae_in;
        if (iniciar_in) begin
          stateNext = ST_IDLE;
          idleNext  = allEmpty;
        end
      end
      ST_IDLE: begin
        if (anyFull) begin
          enterError = 1'b1;
        end else if (!allEmpty) begin
          stateNext = ST_ACTIVE;
          pausaNext = hystPausa;
          contNext  = ~hystPausa;
        end else begin
          idleNext = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (anyFull) begin
          enterError = 1'b1;
        end else if (allEmpty) begin
          stateNext = ST_IDLE;
          idleNext  = 1'b1;
        end else begin
          pausaNext = hystPausa;
          contNext  = ~hystPausa;
        end
      end
      ST_ERROR: begin
        if (err_clr_in) begin
          stateNext = ST_INIT;
        end else begin
          pausaNext = '1;
          errorNext = error | full_in;
        end
      end
      default: begin
        stateNext = ST_RESET;
      end
    endcase

    if (enterError) begin
      stateNext = ST_ERROR;
      pausaNext = '1;
      contNext  = '0;
      errorNext = full_in;
      cntNext   = (err_cnt == {CNT_W{1'b1}}) ? err_cnt : err_cnt + CNT_W'(1);
    end
  end

  // State and output registers: synchronous reset wins, enb low holds everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ        <= ST_RESET;
      umbral_af_out <= AF_RST;
      umbral_ae_out <= AE_RST;
      idle          <= 1'b0;
      pausa         <= '0;
      continuar     <= '0;
      error         <= '0;
      err_cnt       <= '0;
    end else if (enb) begin
      stateQ        <= stateNext;
      umbral_af_out <= afNext;
      umbral_ae_out <= aeNext;
      idle          <= idleNext;
      pausa         <= pausaNext;
      continuar     <= contNext;
      error         <= errorNext;
      err_cnt       <= cntNext;
    end
  end

endmodule
